// File: rtl/nibble_serialiser_tx.sv
// Transmit side of the 4-bit nibble link: buffers host bytes in a small FIFO and
// sends each byte as a high nibble (with valid) followed by a low nibble.
module nibble_serialiser_tx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic             empty,
  output logic             valid,
  output logic [3:0]       nibble,
  input  logic             op_valid,
  output logic             busy,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [7:0]       r_shift;
  logic             r_valid;
  logic [3:0]       r_nibble;
  logic             r_busy;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_frame_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_rd_data;
  logic             w_valid_nxt;
  logic [3:0]       w_nibble_nxt;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_push    = wr_en && !w_full;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_shift  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_shift  <= w_rd_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_nibble <= 4'd0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_valid  <= w_valid_nxt;
      r_nibble <= w_nibble_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  // Outputs are computed for the state being entered, so they register with it.
  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = 1'b0;
    w_nibble_nxt = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt  = S_HIGH;
          w_valid_nxt  = 1'b1;
          w_nibble_nxt = w_rd_data[7:4];
        end
      end
      S_HIGH: begin
        w_state_nxt  = S_LOW;
        w_nibble_nxt = r_shift[3:0];
      end
      S_LOW:   w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
    end else if (r_state == S_GAP) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
      if (!op_valid) r_frame_err <= 1'b1;
    end
  end

  assign full      = w_full;
  assign empty     = w_empty;
  assign valid     = r_valid;
  assign nibble    = r_nibble;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_nibble_serialiser_tx.sv
// Scoreboard bench for nibble_serialiser_tx: a negedge monitor reassembles each
// frame and checks it against bytes queued when they were written.
module tb_nibble_serialiser_tx;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       op_valid = 1'b1;
  logic       full, empty, valid, busy, frame_err;
  logic [3:0] nibble;
  logic [7:0] frame_cnt;

  logic       wr_en2 = 1'b0;
  logic [7:0] wr_data2 = 8'd0;
  logic       op_valid2 = 1'b1;
  logic       full2, empty2, valid2, busy2, frame_err2;
  logic [3:0] nibble2;
  logic [1:0] frame_cnt2;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] q[$];
  int         phase = 0;
  bit         mon_en = 1'b1;
  int         cnt_exp = 0;
  bit         err_exp = 1'b0;
  bit         ov_gap;
  logic [3:0] hi, lo;

  nibble_serialiser_tx #(.DEPTH(4), .CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .valid(valid), .nibble(nibble),
    .op_valid(op_valid), .busy(busy), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  nibble_serialiser_tx #(.DEPTH(4), .CNT_W(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .wr_en(wr_en2), .wr_data(wr_data2),
    .full(full2), .empty(empty2), .valid(valid2), .nibble(nibble2),
    .op_valid(op_valid2), .busy(busy2), .frame_err(frame_err2), .frame_cnt(frame_cnt2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr(input logic [7:0] b, input bit push);
    @(negedge CLK);
    wr_en   = 1'b1;
    wr_data = b;
    if (push) q.push_back(b);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (phase == 0 && q.size() == 0 && empty && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_timeout", 32'(done), 32'd1);
  endtask

  // Frame monitor: phase follows HIGH -> LOW -> GAP -> IDLE as seen at negedges.
  always @(negedge CLK) begin
    if (mon_en && RESET) begin
      case (phase)
        0: if (valid) begin
          hi = nibble;
          chk("busy_high", 32'(busy), 32'd1);
          phase = 1;
        end
        1: begin
          chk("valid_low", 32'(valid), 32'd0);
          lo = nibble;
          if (q.size() == 0) chk("spurious_frame", 32'({hi, lo}), 32'hFFFF_FFFF);
          else chk("byte", 32'({hi, lo}), 32'(q.pop_front()));
          phase = 2;
        end
        2: begin
          chk("gap_valid", 32'(valid), 32'd0);
          chk("gap_nibble", 32'(nibble), 32'd0);
          ov_gap = op_valid;
          phase = 3;
        end
        default: begin
          cnt_exp++;
          if (!ov_gap) err_exp = 1'b1;
          chk("frame_cnt", 32'(frame_cnt), 32'(cnt_exp & 8'hFF));
          chk("frame_err", 32'(frame_err), 32'(err_exp));
          chk("busy_idle", 32'(busy), 32'd0);
          phase = 0;
        end
      endcase
    end
  end

  initial begin
    int seen;
    int w;

    // Reset values
    repeat (3) @(negedge CLK);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_nibble", 32'(nibble), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_cnt2", 32'(frame_cnt2), 32'd0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    // Single frame with latency
    wr(8'hFA, 1'b1);
    @(negedge CLK);
    wr_en = 1'b0;
    chk("lat_valid0", 32'(valid), 32'd0);
    chk("lat_empty", 32'(empty), 32'd0);
    @(negedge CLK);
    chk("lat_valid1", 32'(valid), 32'd1);
    chk("lat_hi", 32'(nibble), 32'hF);
    @(negedge CLK);
    chk("lat_lo", 32'(nibble), 32'hA);
    wait_idle();
    chk("fa_cnt", 32'(frame_cnt), 32'd1);
    chk("fa_err", 32'(frame_err), 32'd0);

    // Back-to-back burst: fifth write fills the FIFO, sixth is dropped
    wr(8'hD5, 1'b1);
    wr(8'h3C, 1'b1);
    wr(8'h81, 1'b1);
    wr(8'h07, 1'b1);
    wr(8'h5A, 1'b1);
    wr(8'hEE, 1'b0);
    chk("burst_full", 32'(full), 32'd1);
    @(negedge CLK);
    wr_en = 1'b0;
    chk("burst_after_drop", 32'(full), 32'd0);
    wait_idle();
    chk("burst_cnt", 32'(frame_cnt), 32'd6);

    // Missing acknowledge sets a sticky error, count still advances
    op_valid = 1'b0;
    wr(8'h12, 1'b1);
    @(negedge CLK);
    wr_en = 1'b0;
    wait_idle();
    chk("err_set", 32'(frame_err), 32'd1);
    chk("err_cnt", 32'(frame_cnt), 32'd7);
    op_valid = 1'b1;
    wr(8'h34, 1'b1);
    @(negedge CLK);
    wr_en = 1'b0;
    wait_idle();
    chk("err_sticky", 32'(frame_err), 32'd1);
    chk("err_cnt2", 32'(frame_cnt), 32'd8);

    // Reset mid-frame with two bytes queued
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    mon_en = 1'b0;
    q.delete();
    phase = 0;
    cnt_exp = 0;
    err_exp = 1'b0;
    chk("pre_cnt", 32'(frame_cnt), 32'd0);
    chk("pre_err", 32'(frame_err), 32'd0);
    wr(8'hC3, 1'b0);
    wr(8'hA1, 1'b0);
    wr(8'hB2, 1'b0);
    @(negedge CLK);
    wr_en = 1'b0;
    chk("mid_low_nibble", 32'(nibble), 32'h3);
    chk("mid_busy", 32'(busy), 32'd1);
    #1 RESET = 1'b0;
    #1;
    chk("mid_valid", 32'(valid), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_full", 32'(full), 32'd0);
    chk("mid_busy0", 32'(busy), 32'd0);
    chk("mid_cnt", 32'(frame_cnt), 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (valid || busy) seen++;
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);
    chk("post_rst_cnt", 32'(frame_cnt), 32'd0);
    mon_en = 1'b1;

    // Narrow counter wraps: 1,2,3,0,1
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      wr_en2   = 1'b1;
      wr_data2 = 8'(8'h40 + i);
      @(negedge CLK);
      wr_en2 = 1'b0;
      w = 0;
      while (!busy2 && w < 20) begin @(negedge CLK); w++; end
      while (busy2 && w < 40) begin @(negedge CLK); w++; end
      chk("wrap_timeout", 32'(w < 40), 32'd1);
      chk("wrap_cnt", 32'(frame_cnt2), 32'((i + 1) % 4));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
